// File: rtl/level_select_n_pkg.sv
// Shared state encoding and error codes for the level-select front end.
package level_sel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    RELEASE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_MULTI  = 2'd1;
  localparam logic [1:0] ERR_LOCKED = 2'd2;

endpackage

// File: rtl/level_select_n_key_debounce.sv
// One raw key: 2-flop synchroniser, debounce counter, one-cycle press pulse on a debounced rise.
// Raw high first sampled at edge k gives press high after edge k+1+DEBOUNCE_CYC; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample that agrees with the debounced value restarts the count.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        deb   <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/level_select_n.sv
// Level-select front end: debounced keys, coincidence window, level lock, clear -> soft_rst pulse.
// Outputs registered; level valid 3+DEBOUNCE_CYC+WINDOW_CYC edges after raw press. LEVEL_RESELECT_EN allows re-selection while locked.
module level_select_n
  import level_sel_pkg::*;
#(
  parameter int NUM_LEVELS   = 3,
  parameter int LEVEL_W      = 3,
  parameter int DEBOUNCE_CYC = 1,
  parameter int WINDOW_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LEVELS-1:0] key_level,
  input  logic                  key_clear,
  output logic [LEVEL_W-1:0]    level,
  output logic                  end_signal,
  output logic                  soft_rst,
  output logic [1:0]            error_code
);

  localparam int WC_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

  logic [NUM_LEVELS-1:0] lvl_deb;
  logic [NUM_LEVELS-1:0] lvl_press;
  logic                  clr_press;
  logic                  clr_deb_unused;

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_level[i]),
      .deb   (lvl_deb[i]),
      .press (lvl_press[i])
    );
  end

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (key_clear),
    .deb   (clr_deb_unused),
    .press (clr_press)
  );

  state_t                state, state_nxt;
  logic [WC_W-1:0]       win_cnt, win_cnt_nxt;
  logic [NUM_LEVELS-1:0] mask, mask_nxt;
  // Keys held across a clear; they stay ignored until released.
  logic [NUM_LEVELS-1:0] stale, stale_nxt;
  logic [LEVEL_W-1:0]    level_nxt;
  logic                  end_nxt;
  logic                  soft_nxt;
  logic [1:0]            err_nxt;
`ifdef LEVEL_RESELECT_EN
  logic                  resel, resel_nxt;
`endif

  logic [NUM_LEVELS-1:0] fresh_press;
  logic [NUM_LEVELS-1:0] win_mask;
  logic [3:0]            ones;
  logic [LEVEL_W-1:0]    sel;

  assign fresh_press = lvl_press & ~stale;
  assign win_mask    = mask | fresh_press | (lvl_deb & ~stale);

  always_comb begin
    ones = '0;
    sel  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (win_mask[i]) begin
        ones = ones + 4'd1;
        sel  = LEVEL_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      mask       <= '0;
      stale      <= '0;
      level      <= '0;
      end_signal <= 1'b0;
      soft_rst   <= 1'b0;
      error_code <= ERR_NONE;
`ifdef LEVEL_RESELECT_EN
      resel      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      win_cnt    <= win_cnt_nxt;
      mask       <= mask_nxt;
      stale      <= stale_nxt;
      level      <= level_nxt;
      end_signal <= end_nxt;
      soft_rst   <= soft_nxt;
      error_code <= err_nxt;
`ifdef LEVEL_RESELECT_EN
      resel      <= resel_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    mask_nxt    = mask;
    stale_nxt   = stale & lvl_deb;
    level_nxt   = level;
    end_nxt     = end_signal;
    soft_nxt    = 1'b0;
    err_nxt     = error_code;
`ifdef LEVEL_RESELECT_EN
    resel_nxt   = resel;
`endif
    if (clr_press) begin
      state_nxt   = IDLE;
      win_cnt_nxt = '0;
      mask_nxt    = '0;
      stale_nxt   = lvl_deb;
      level_nxt   = '0;
      end_nxt     = 1'b0;
      soft_nxt    = 1'b1;
      err_nxt     = ERR_NONE;
`ifdef LEVEL_RESELECT_EN
      resel_nxt   = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|fresh_press) begin
            state_nxt   = WINDOW;
            win_cnt_nxt = WC_W'(WINDOW_CYC - 1);
            mask_nxt    = fresh_press;
          end
        end
        WINDOW: begin
          mask_nxt = win_mask;
          if (win_cnt == '0) begin
            mask_nxt = '0;
`ifdef LEVEL_RESELECT_EN
            resel_nxt = 1'b0;
`endif
            if (ones == 4'd1) begin
              state_nxt = LOCKED;
              level_nxt = sel;
              end_nxt   = 1'b1;
              err_nxt   = ERR_NONE;
            end else if (ones != 4'd0) begin
              err_nxt   = ERR_MULTI;
`ifdef LEVEL_RESELECT_EN
              state_nxt = resel ? LOCKED : RELEASE;
`else
              state_nxt = RELEASE;
`endif
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            win_cnt_nxt = win_cnt - WC_W'(1);
          end
        end
        RELEASE: begin
          if (lvl_deb == '0) state_nxt = IDLE;
        end
        LOCKED: begin
          if (|fresh_press) begin
`ifdef LEVEL_RESELECT_EN
            state_nxt   = WINDOW;
            win_cnt_nxt = WC_W'(WINDOW_CYC - 1);
            mask_nxt    = fresh_press;
            resel_nxt   = 1'b1;
`else
            err_nxt = ERR_LOCKED;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/level_select_n.md
Name: level_select_n

Overview:
- Parametrised successor of the game's level-select front end.
- Takes NUM_LEVELS raw keypad lines plus a clear key. Each key is synchronised and debounced.
- Simultaneous presses are resolved inside a coincidence window. A single valid press latches a level number; multi-press is rejected with an error code.
- Drives the level, end_signal and a soft-reset pulse to the downstream game controller.

Parameters:
- NUM_LEVELS, 3, number of level keys; key bit i selects level i+1. Legal range 1..7.
- LEVEL_W, 3, width of the level output. Must satisfy 2**LEVEL_W > NUM_LEVELS.
- DEBOUNCE_CYC, 1, number of consecutive equal synchronised samples required before a debounced key changes. Must be ≥1.
- WINDOW_CYC, 2, coincidence window in cycles after the first debounced press. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_level  in  NUM_LEVELS  raw asynchronous level keys; bit i corresponds to level i+1.
- key_clear  in  1  raw asynchronous clear key (keypad 0).
- level  out  LEVEL_W  selected level; 0 = none.
- end_signal  out  1  high while a level is locked.
- soft_rst  out  1  one-cycle pulse issued on a debounced clear press.
- error_code  out  2  0 = none, 1 = multi-press rejected, 2 = press ignored while locked.

Behaviour:
- Clock and reset: single clock domain clk. rst is synchronous and active-high.
- Reset values: level=0, end_signal=0, soft_rst=0, error_code=0, state=IDLE. Reset also clears all synchronisers, debouncers and the window counter.
- Synchroniser: each key passes through a 2-flop synchroniser.
- Debounce:
  - The debounced value toggles after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles.
  - A rising edge of the debounced value is a "press".
  - Pipeline: raw high at edge k gives a press visible at edge k+2+DEBOUNCE_CYC.
- States and transitions:
  - IDLE:
    - Any level press → WINDOW; window counter loaded with WINDOW_CYC-1; press mask loaded with the pressed bits.
  - WINDOW:
    - Each cycle, OR newly pressed and currently debounced-high level keys into the mask.
    - When the counter reaches 0, evaluate the mask.
    - Popcount 1 → LOCKED: level = index+1, error_code = 0.
    - Popcount ≥2 → RELEASE: error_code = 1, level stays 0.
  - RELEASE:
    - Wait until all debounced level keys are low, then → IDLE.
    - Presses seen here are ignored.
  - LOCKED:
    - end_signal = 1; level is held.
    - Any level press sets error_code = 2; level is unchanged (but see LEVEL_RESELECT_EN).
- Clear key:
  - A debounced clear press in any state has top priority over all level presses in the same cycle.
  - Next edge: soft_rst = 1 for exactly one cycle; level = 0; end_signal = 0; error_code = 0; mask cleared; state → IDLE.
  - Level keys still held after a clear must be released and pressed again before they count; only a fresh press is accepted.
- Latency, single clean press (DEBOUNCE_CYC=1, WINDOW_CYC=2): level and end_signal valid at edge k+5, where k is the first edge sampling the key high.
- Presses shorter than one clock period may be lost; this is not an error.
- Holding a key does not repeat the press.
- rst asserted mid-window or mid-release aborts to the reset values immediately at that edge; soft_rst is not pulsed by rst.
- Outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: LEVEL_RESELECT_EN.
- Defined:
  - In LOCKED, a level press enters WINDOW while keeping the old level and end_signal=1 during the window.
  - Popcount 1 → LOCKED with the new level.
  - Popcount ≥2 → LOCKED with the old level and error_code = 1.
- Undefined: LOCKED ignores level presses and sets error_code = 2. This is the default build.

Decomposition:
- Package level_sel_pkg:
  - State encoding: IDLE, WINDOW, RELEASE, LOCKED.
  - Error code constants: ERR_NONE=2'd0, ERR_MULTI=2'd1, ERR_LOCKED=2'd2.
- Sub-module key_debounce, parametrised by DEBOUNCE_CYC:
  - Contains the 2-flop synchroniser, the debounce counter and press-edge detection.
  - Instantiated NUM_LEVELS+1 times: one per level key plus one for the clear key.

Test Plan:
1. rst for 2 cycles, then key_level=3'b001 for 1 cycle → level=1 and end_signal=1 at edge k+5; soft_rst stays 0.
2. Locked at level 1, press key_level=3'b010 → level stays 1, error_code=2 (default build); with LEVEL_RESELECT_EN → level=2, error_code=0.
3. key_clear for 1 cycle → soft_rst high for exactly one cycle, then level=0, end_signal=0, error_code=0.
4. key_level=3'b110 simultaneously, and separately bit 1 then bit 2 one cycle apart → both give error_code=1, level=0. A following single press is only accepted after all keys are released.
5. key_level bit 2 asserted 7 ns after a clock edge (asynchronous), held 10 ns → level=3 and end_signal=1; with DEBOUNCE_CYC=4, a 2-cycle glitch produces no press and level stays 0.
6. key_clear and key_level=3'b001 pressed in the same cycle → soft_rst pulse, level=0. rst asserted mid-WINDOW → all outputs return to reset values at that edge with no soft_rst pulse.
